inst_prefetch_buf: RTL and testbench
====================================

# inst_prefetch_buf

Parametrised instruction prefetch unit between halfword instruction memory and the core's IF stage. Replaces the fixed one-halfword-per-cycle PC stepping with a multi-halfword fetch port, a halfword queue, Thumb-2 16/32-bit instruction assembly, back-pressure from the core, and redirect (flush) to an arbitrary halfword address.

## Interface
- `ADDR_W`, 21: halfword address width.
- `FETCH_HW`, 2: halfwords per memory beat; power of 2, 1..4.
- `DEPTH`, 8: queue entries (halfwords); power of 2, ≥ 2*FETCH_HW.
- `MAX_OUT`, 2: maximum outstanding memory requests, 1..4.
- `RESET_PC`, 0: halfword fetch address after reset.

- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  ADDR_W  beat address; low log2(FETCH_HW) bits always 0.
- `mem_gnt`  in  1  request accepted when `mem_req && mem_gnt`.
- `mem_rvalid`  in  1  read data valid; in request order, ≥1 cycle after grant.
- `mem_rdata`  in  16*FETCH_HW  beat data; bits [15:0] = lowest address.
- `flush`  in  1  redirect.
- `flush_addr`  in  ADDR_W  new halfword PC.
- `inst`  out  32  assembled instruction: 32-bit = {hw0,hw1}; 16-bit = {hw0,16'h0}.
- `inst_is32`  out  1  head is a 32-bit Thumb-2 instruction.
- `inst_pc`  out  ADDR_W  halfword address of `inst`.
- `inst_valid`  out  1  `inst` complete and valid.
- `inst_ready`  in  1  core consumes `inst` when `inst_valid && inst_ready`.

## Operation
- 32-bit prefix: hw[15:11] ∈ {11101,11110,11111}; otherwise 16-bit.
- Fetch pointer `fpc` (beat-aligned) and `skip` (halfwords to discard from the next accepted beat). Reset: `fpc`=RESET_PC aligned down, `skip`=RESET_PC mod FETCH_HW.
- Issue: `mem_req`=1 iff outstanding < MAX_OUT and count + (outstanding+1)*FETCH_HW ≤ DEPTH (count = current occupancy, before pop). On grant: `fpc` += FETCH_HW (wraps modulo 2^ADDR_W); outstanding +1.
- Response: outstanding −1; if `drop` > 0, `drop` −1 and data discarded; else push halfwords FETCH_HW−`skip` (lanes ≥ `skip`) in ascending lane order, then clear `skip`.
- Output: head hw0 16-bit → `inst_valid`=count≥1. Head 32-bit → `inst_valid`=count≥2. Pop 1 or 2 halfwords; `inst_pc` += 1 or 2.
- Flush (highest priority): queue emptied; `drop` = outstanding after this cycle's grant/response; `fpc`=`flush_addr` aligned; `skip`=`flush_addr` mod FETCH_HW; `inst_pc`=`flush_addr`. Same-cycle pop, push, and grant are discarded (a same-cycle grant is counted in `drop`).
- Simultaneous push and pop in one cycle are both applied. Full queue: no request issued; never overflows by construction.
- Reset mid-operation: all state returns to reset values immediately; in-flight responses after reset release are not expected (memory is reset together).

## Timing
- Reset outputs: `mem_req`=0, `mem_addr`=RESET_PC aligned, `inst`=0, `inst_is32`=0, `inst_pc`=RESET_PC, `inst_valid`=0.
- `mem_req` first asserts in the first cycle after `rst_n` deasserts. It is registered: it reflects state after the previous edge.
- `inst`, `inst_is32`, and `inst_valid` are combinational from the queue head. No combinational path from `inst_ready` or `mem_rvalid` to any output.
- Redirect latency with a 1-cycle memory: flush sampled at edge N, request+grant in cycle N+1, `mem_rvalid` in N+2, `inst_valid` in N+3.
- Steady state with `mem_gnt`=1, 1-cycle memory and FETCH_HW≥2: one instruction per cycle is sustained.

## Structure
- Package `arm_fetch_pkg`: function `is_thumb32(hw)`, prefix constants, and the halfword type.
- Sub-module `prefetch_hw_queue`: circular halfword FIFO, DEPTH entries, write 0..FETCH_HW, read 0..2, peek of head and head+1, occupancy count of log2(DEPTH)+1 bits, synchronous clear.
- Top holds `fpc`, `skip`, `drop`, the outstanding counter, and the pop/flush control.

## Test plan
- Reset, then memory holds 0x2001, 0x4608, … with 1-cycle latency and `inst_ready`=1 → `inst`=0x20010000 and `inst_pc`=0 in cycle 3; thereafter one 16-bit instruction per cycle with `inst_pc` incrementing by 1.
- Halfwords 0xF000, 0xF800 (BL) at address 4 → `inst_is32`=1, `inst`=0xF000F800, `inst_pc`=4; next `inst_pc`=6.
- 32-bit prefix at address 7 with FETCH_HW=2 (split across beats) → `inst_valid` stays 0 until the beat at 8 arrives, then `inst_pc`=7 with the full 32-bit `inst`.
- `inst_ready`=0 for 20 cycles → queue fills to DEPTH, `mem_req` drops, and no data is lost when ready returns.
- `flush`, `flush_addr`=0x13, with 2 requests outstanding and a response in the same cycle → both stale beats dropped; first output `inst_pc`=0x13 from lane 1 of beat 0x12.
- `mem_gnt` toggling randomly with latency 1–3, checked against a reference PC model → no duplicate or skipped halfwords; `mem_addr` wraps from 0x1FFFFE to 0.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared Thumb-2 fetch types: the halfword type, the 32-bit encoding prefixes
// and the instruction-length decode used by the prefetch buffer.
package arm_fetch_pkg;

    typedef logic [15:0] hw_t;

    localparam logic [4:0] T32_PFX_A = 5'b11101;
    localparam logic [4:0] T32_PFX_B = 5'b11110;
    localparam logic [4:0] T32_PFX_C = 5'b11111;

    function automatic logic is_thumb32(input hw_t hw);
        return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
               (hw[15:11] == T32_PFX_C);
    endfunction

endpackage

// File: rtl/prefetch_hw_queue.sv
// Circular halfword FIFO: writes up to WR_MAX halfwords and reads up to two
// per cycle, exposing the head pair and the occupancy count.
module prefetch_hw_queue
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WR_MAX = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int WC_W  = $clog2(WR_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [16*WR_MAX-1:0]  wr_data,
    input  logic [WC_W-1:0]       wr_cnt,
    input  logic [1:0]            rd_cnt,
    output hw_t                   head0,
    output hw_t                   head1,
    output logic [CNT_W-1:0]      count
);

    hw_t              mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Lane i of wr_data lands at wr_ptr+i; storage needs no reset because
    // count gates every use of the head.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_MAX; i++) begin
            if (!clear && (WC_W'(i) < wr_cnt))
                mem[wr_ptr + PTR_W'(i)] <= wr_data[16*i +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
            rd_ptr <= rd_ptr + PTR_W'(rd_cnt);
            count  <= count + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch unit: multi-halfword fetch beats into a halfword queue,
// Thumb-2 16/32-bit assembly at the head, back-pressure and redirect.
module inst_prefetch_buf
    import arm_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 21,
    parameter int                FETCH_HW = 2,
    parameter int                DEPTH    = 8,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [16*FETCH_HW-1:0] mem_rdata,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_addr,
    output logic [31:0]            inst,
    output logic                   inst_is32,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready
);

    localparam int SKIP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int WC_W   = $clog2(FETCH_HW + 1);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] OFS_MASK   = ADDR_W'(FETCH_HW - 1);
    localparam logic [ADDR_W-1:0] RESET_FPC  = RESET_PC & ~OFS_MASK;
    localparam logic [SKIP_W-1:0] RESET_SKIP = SKIP_W'(RESET_PC & OFS_MASK);

    logic [ADDR_W-1:0] fpc;
    logic [SKIP_W-1:0] skip;
    logic [OUT_W-1:0]  drop;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_next;
    logic [ADDR_W-1:0] pc_q;
    logic              run;

    hw_t               head0;
    hw_t               head1;
    logic [CNT_W-1:0]  q_count;
    logic              head_is32;
    logic              grant;
    logic              take;
    logic              pop;
    logic [WC_W-1:0]   wr_cnt;
    logic [1:0]        rd_cnt;
    logic [16*FETCH_HW-1:0] wr_data;

    // Handshakes: a memory request transfers when mem_req && mem_gnt, and an
    // instruction transfers when inst_valid && inst_ready; neither valid ever
    // depends combinationally on its ready or on mem_rvalid.
    assign mem_req  = run && (outstanding < OUT_W'(MAX_OUT)) &&
                      ((int'(q_count) + (int'(outstanding) + 1) * FETCH_HW) <= DEPTH);
    assign mem_addr = fpc;
    assign grant    = mem_req && mem_gnt;
    assign take     = mem_rvalid && (drop == '0) && !flush;
    assign out_next = outstanding + OUT_W'(grant) - OUT_W'(mem_rvalid);

    assign wr_data  = mem_rdata >> {skip, 4'b0000};
    assign wr_cnt   = take ? (WC_W'(FETCH_HW) - WC_W'(skip)) : '0;

    assign head_is32  = is_thumb32(head0);
    assign inst_valid = head_is32 ? (q_count >= CNT_W'(2)) : (q_count >= CNT_W'(1));
    assign inst_is32  = (q_count != '0) && head_is32;
    assign inst       = (q_count == '0) ? 32'h0 :
                        head_is32       ? {head0, head1} : {head0, 16'h0};
    assign inst_pc    = pc_q;

    assign pop    = inst_valid && inst_ready && !flush;
    assign rd_cnt = !pop ? 2'd0 : (head_is32 ? 2'd2 : 2'd1);

    prefetch_hw_queue #(
        .DEPTH  (DEPTH),
        .WR_MAX (FETCH_HW)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .wr_data (wr_data),
        .wr_cnt  (wr_cnt),
        .rd_cnt  (rd_cnt),
        .head0   (head0),
        .head1   (head1),
        .count   (q_count)
    );

    // A flush keeps counting outstanding beats; all of them, including one
    // granted in the flush cycle, are marked to be dropped on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_FPC;
            skip        <= RESET_SKIP;
            drop        <= '0;
            outstanding <= '0;
            pc_q        <= RESET_PC;
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_next;
            if (flush) begin
                fpc  <= flush_addr & ~OFS_MASK;
                skip <= SKIP_W'(flush_addr & OFS_MASK);
                drop <= out_next;
                pc_q <= flush_addr;
            end else begin
                if (grant)
                    fpc <= fpc + ADDR_W'(FETCH_HW);
                if (mem_rvalid) begin
                    if (drop != '0)
                        drop <= drop - OUT_W'(1);
                    else
                        skip <= '0;
                end
                if (pop)
                    pc_q <= pc_q + (head_is32 ? ADDR_W'(2) : ADDR_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Bench for inst_prefetch_buf: in-order memory responder, expected-instruction
// queue checked by a monitor, and directed phases for the listed scenarios.
`timescale 1ns/1ps
module tb_inst_prefetch_buf;

    localparam int ADDR_W   = 21;
    localparam int FETCH_HW = 2;
    localparam int DEPTH    = 8;
    localparam int MAX_OUT  = 2;
    localparam int EXP_W    = 32 + 1 + ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   mem_req;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [16*FETCH_HW-1:0] mem_rdata;
    logic                   flush;
    logic [ADDR_W-1:0]      flush_addr;
    logic [31:0]            inst;
    logic                   inst_is32;
    logic [ADDR_W-1:0]      inst_pc;
    logic                   inst_valid;
    logic                   inst_ready;

    logic [EXP_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    int                cyc      = 0;
    int                fixed_lat = 1;
    bit                rand_lat = 0;
    bit                rand_gnt = 0;
    bit                wrap_seen = 0;
    bit                misaligned = 0;
    logic [ADDR_W-1:0] last_gnt = '0;

    inst_prefetch_buf #(
        .ADDR_W   (ADDR_W),
        .FETCH_HW (FETCH_HW),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (21'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .flush_addr (flush_addr),
        .inst       (inst),
        .inst_is32  (inst_is32),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---- memory image: directed instructions, 16-bit filler elsewhere ----
    function automatic logic [15:0] img(input logic [ADDR_W-1:0] a);
        case (a)
            21'h0:   return 16'h2001;
            21'h1:   return 16'h4608;
            21'h4:   return 16'hF000;
            21'h5:   return 16'hF800;
            21'h7:   return 16'hE800;
            21'h8:   return 16'h0001;
            default: return {8'h46, a[7:0]};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] i, input logic s, input logic [ADDR_W-1:0] p);
        exp_q.push_back({i, s, p});
    endtask

    // Reference PC walk over the memory image.
    task automatic expect_stream(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] pc;
        logic [15:0]       h;
        pc = start;
        for (int k = 0; k < n; k++) begin
            h = img(pc);
            if (h[15:13] == 3'b111 && h[12:11] != 2'b00) begin
                push_exp({h, img(pc + 21'd1)}, 1'b1, pc);
                pc = pc + 21'd2;
            end else begin
                push_exp({h, 16'h0}, 1'b0, pc);
                pc = pc + 21'd1;
            end
        end
    endtask

    task automatic drain(input string name, input int budget, input bit rnd);
        int k;
        k = 0;
        while (k < budget) begin
            @(posedge clk); #1;
            k++;
            if (exp_q.size() == 0) break;
            if (rnd) inst_ready = ($urandom_range(3, 0) != 0);
        end
        inst_ready = 1'b0;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    // ---- memory responder: in order, latency fixed or random 1..3 ----
    initial begin
        logic [ADDR_W-1:0] a;
        int due;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (mem_req && mem_gnt) begin
                if (mem_addr[0] !== 1'b0) misaligned = 1;
                if (last_gnt == 21'h1FFFFE && mem_addr == 21'h0) wrap_seen = 1;
                last_gnt = mem_addr;
                due = cyc + (rand_lat ? int'($urandom_range(3, 1)) : fixed_lat);
                if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
                pend_addr.push_back(mem_addr);
                pend_due.push_back(due);
            end
            @(posedge clk); #1;
            cyc++;
            if (rst_n && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                mem_rvalid = 1'b1;
                mem_rdata  = {img(a + 21'd1), img(a)};
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            mem_gnt = rand_gnt ? ($urandom_range(1, 0) == 1) : 1'b1;
        end
    end

    // ---- scoreboard monitor ----
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra: got inst %h at pc %h, expected no instruction", inst, inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst", 64'(inst), 64'(e[EXP_W-1 -: 32]));
                    check("sb_is32", 64'(inst_is32), 64'(e[ADDR_W]));
                    check("sb_pc", 64'(inst_pc), 64'(e[ADDR_W-1:0]));
                end
            end
        end
    end

    // ---- directed phases ----
    initial begin
        int  k;
        bit  found;
        rst_n = 1'b0; flush = 1'b0; flush_addr = '0; inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_is32", 64'(inst_is32), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);

        // Phase A: straight-line stream from reset, including BL at 4 and a 32-bit at 7
        @(posedge clk); #1;
        rst_n = 1'b1; inst_ready = 1'b1;
        push_exp(32'h20010000, 1'b0, 21'h0);
        push_exp(32'h46080000, 1'b0, 21'h1);
        push_exp(32'h46020000, 1'b0, 21'h2);
        push_exp(32'h46030000, 1'b0, 21'h3);
        push_exp(32'hF000F800, 1'b1, 21'h4);
        push_exp(32'h46060000, 1'b0, 21'h6);
        push_exp(32'hE8000001, 1'b1, 21'h7);
        push_exp(32'h46090000, 1'b0, 21'h9);
        push_exp(32'h460A0000, 1'b0, 21'hA);
        @(negedge clk);
        check("a_c0_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("a_c1_req", 64'(mem_req), 64'd1);
        check("a_c1_addr", 64'(mem_addr), 64'd0);
        check("a_c1_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("a_c2_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("a_c3_valid", 64'(inst_valid), 64'd1);
        check("a_c3_inst", 64'(inst), 64'h20010000);
        check("a_c3_pc", 64'(inst_pc), 64'd0);
        @(posedge clk); #1;
        drain("a_stream", 60, 1'b0);

        // Phase B: back-pressure fills the queue, then drains without loss
        flush = 1'b1; flush_addr = 21'h20; exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        settle();
        @(negedge clk);
        check("b_full_req", 64'(mem_req), 64'd0);
        check("b_full_valid", 64'(inst_valid), 64'd1);
        check("b_full_pc", 64'(inst_pc), 64'h20);
        @(posedge clk); #1;
        expect_stream(21'h20, 12);
        inst_ready = 1'b1;
        drain("b_refill", 80, 1'b0);

        // Phase C: 32-bit instruction at 7 split across beats 6 and 8
        settle();
        flush = 1'b1; flush_addr = 21'h7; inst_ready = 1'b1;
        push_exp(32'hE8000001, 1'b1, 21'h7);
        push_exp(32'h46090000, 1'b0, 21'h9);
        push_exp(32'h460A0000, 1'b0, 21'hA);
        push_exp(32'h460B0000, 1'b0, 21'hB);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("c_req", 64'(mem_req), 64'd1);
        check("c_addr", 64'(mem_addr), 64'h6);
        check("c_wait1", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("c_wait2", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("c_wait3", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("c_split_valid", 64'(inst_valid), 64'd1);
        check("c_split_inst", 64'(inst), 64'hE8000001);
        check("c_split_pc", 64'(inst_pc), 64'h7);
        @(posedge clk); #1;
        drain("c_stream", 40, 1'b0);

        // Phase D: flush to 0x13 with two beats in flight and one returning
        settle();
        fixed_lat = 2;
        flush = 1'b1; flush_addr = 21'h40;
        @(posedge clk); #1;
        flush = 1'b0;
        k = 0; found = 0;
        while (!found && k < 40) begin
            @(posedge clk); #2;
            k++;
            if (mem_rvalid && pend_addr.size() == 1) found = 1;
        end
        check("d_window", 64'(found), 64'd1);
        flush = 1'b1; flush_addr = 21'h13; inst_ready = 1'b1;
        expect_stream(21'h13, 6);
        @(posedge clk); #1;
        flush = 1'b0;
        drain("d_stream", 60, 1'b0);

        // Phase E: random grant, latency 1..3, random ready, across the wrap
        settle();
        rand_gnt = 1; rand_lat = 1;
        flush = 1'b1; flush_addr = 21'h1FFFF9; inst_ready = 1'b1;
        expect_stream(21'h1FFFF9, 30);
        @(posedge clk); #1;
        flush = 1'b0;
        drain("e_stream", 800, 1'b1);
        check("e_addr_wrap", 64'(wrap_seen), 64'd1);
        check("e_aligned", 64'(misaligned), 64'd0);

        // Phase F: reset in the middle of random traffic, then restart from 0
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        check("f_rst_req", 64'(mem_req), 64'd0);
        check("f_rst_valid", 64'(inst_valid), 64'd0);
        check("f_rst_pc", 64'(inst_pc), 64'd0);
        check("f_rst_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1;
        rand_gnt = 0; rand_lat = 0; fixed_lat = 1;
        @(posedge clk); #1;
        rst_n = 1'b1; inst_ready = 1'b1;
        expect_stream(21'h0, 5);
        drain("f_restart", 40, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
